// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and requester indices
package regfile_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [31:0] SP_RESET = 32'h000000FC;
  localparam int REQ_ALU = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MULDIV = 2;
endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searched from ptr+1, pointer follows the winner
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      winner,
  output logic               accept
);
  logic [PW-1:0] ptr;
  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    grant = '0;
    winner = '0;
    accept = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
      if (!accept && valid[idx]) begin
        grant[idx] = 1'b1;
        winner = idx;
        accept = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr <= PW'(NUM_REQ - 1);
    else if (accept) ptr <= winner;
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates writebacks onto the register-file write port
// and tracks outstanding destinations to stall decode on RAW/WAW hazards.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_enable,
  output logic [ADDR_W-1:0]         wr_address,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2:0]                grant_id,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_dest,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
  output logic                      hazard_stall
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [PW-1:0] winner;
  logic accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0] busy, set_mask, clr_mask;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .clock(clock), .reset(reset), .valid(req_valid),
    .grant(req_ready), .winner(winner), .accept(accept)
  );
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
  end
  assign hazard_stall = (rs_addr != ZERO && busy[rs_addr]) |
                        (rt_addr != ZERO && busy[rt_addr]) |
                        (issue_dest != ZERO && busy[issue_dest]);
  assign set_mask = (issue_valid && !hazard_stall && issue_dest != ZERO) ? NREG'(1) << issue_dest : '0;
  assign clr_mask = (accept && sel_addr != ZERO) ? NREG'(1) << sel_addr : '0;
  // set applied after clear: a same-edge reissue is a newer reservation
  always_ff @(posedge clock or posedge reset)
    if (reset) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_enable <= 1'b0;
      wr_address <= '0;
      wr_data <= '0;
      grant_id <= '0;
    end else begin
      wr_enable <= accept && sel_addr != ZERO;
      if (accept) begin
        wr_address <= sel_addr;
        wr_data <= sel_data;
        grant_id <= 3'(winner);
      end
    end
endmodule
